// File: rtl/rd_fwft_out_stage.sv
// Read-side output stage of the async FIFO: issues memory reads against the
// registered empty flag and presents the data as a FWFT valid/ready stream.
module rd_fwft_out_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_RD_clk,
  input  logic             i_RD_rst,
  input  logic             i_Empty,
  output logic             o_RD_En,
  input  logic [WIDTH-1:0] i_RD_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Data,
  output logic [1:0]       o_Count
);

  logic [1:0]       occ;
  logic             infl;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  logic             pop;
  logic [1:0]       in_use;
  logic [1:0]       occ_after_pop;

  always_comb begin
    pop           = (occ != 2'd0) & i_Ready;
    in_use        = occ + {1'b0, infl};
    occ_after_pop = occ - {1'b0, pop};
    // A read is only issued when its data is guaranteed a free slot on arrival.
    o_RD_En       = ~i_RD_rst & ~i_Empty & ((in_use < 2'd2) | pop);
  end

  always_ff @(posedge i_RD_clk) begin
    if (i_RD_rst) begin
      occ  <= '0;
      infl <= 1'b0;
      head <= '0;
      tail <= '0;
    end else begin
      infl <= o_RD_En;
      occ  <= occ_after_pop + {1'b0, infl};
      if (pop && (occ == 2'd2)) begin
        head <= tail;
      end
      // Arriving word lands in the first slot left free after this cycle's pop.
      if (infl) begin
        if (occ_after_pop == 2'd0) begin
          head <= i_RD_Data;
        end else begin
          tail <= i_RD_Data;
        end
      end
    end
  end

  assign o_Valid = (occ != 2'd0);
  assign o_Data  = head;
  assign o_Count = occ;

endmodule
